soc_mem_ctrl: RTL and testbench

Parametrised memory and peripheral slave for the picorv32 native memory interface. It is the next generation of the single-cycle, always-ready test-SoC memory. Compared with that memory it adds:
- configurable RAM depth and wait states;
- a registered valid/ready response state machine;
- several buffered byte-output channels with backpressure;
- a sticky bus-error flag for unmapped accesses.

It sits between the CPU core and the board-level outputs in FPGA and simulation SoC tops.

---
 rtl/soc_mem_pkg.sv | 50 +++++
 rtl/byte_fifo.sv | 56 +++++
 rtl/soc_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_soc_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// Shared types and helpers for the SoC memory / byte-output slave.
package soc_mem_pkg;

    // Request sequencing: accept, wait out the access time, answer for one cycle.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // Where a latched address lands.
    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_CHAN,
        DEC_NONE
    } dec_kind_e;

    typedef struct packed {
        dec_kind_e  kind;
        logic [2:0] chan;
    } dec_t;

    // Channel status word layout: {16'b0, count[7:0], 6'b0, full, empty}.
    localparam int ST_EMPTY_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_CNT_LSB   = 8;
    localparam int ST_CNT_W     = 8;

    // RAM occupies word addresses below mem_words; channel k sits at out_base + 4*k.
    function automatic dec_t decode(input logic [31:0] addr,
                                    input logic [31:0] mem_words,
                                    input logic [31:0] out_base,
                                    input int          num_out);
        dec_t r;
        r.kind = DEC_NONE;
        r.chan = '0;
        if ({2'b00, addr[31:2]} < mem_words) begin
            r.kind = DEC_RAM;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (k < num_out && addr == out_base + 32'(4 * k)) begin
                    r.kind = DEC_CHAN;
                    r.chan = 3'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO feeding one output channel; head is presented unregistered.
module byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem[rd_q];
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        rd_d  = rd_q + AW'(do_pop);
        wr_d  = wr_q + AW'(do_push);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/soc_mem_ctrl.sv
// picorv32 native-bus slave: wait-stated RAM, buffered byte channels, bus-error flag.
module soc_mem_ctrl
    import soc_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 4096,
    parameter int          WAIT_STATES = 0,
    parameter int          NUM_OUT     = 2,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] OUT_BASE    = 32'h1000_0000,
    parameter string       MEM_INIT    = "firmware.hex"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready,
    output logic [8*NUM_OUT-1:0] out_data,
    output logic                 bus_err,
    output logic                 monitor_valid,
    output logic [31:0]          monitor_addr,
    output logic [31:0]          monitor_data
);

    localparam int         AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int         CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_e      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bus_err_q, bus_err_d;
    logic        skip_q, skip_d;

    logic [31:0] ram [MEM_WORDS];
    logic [AW-1:0] widx;
    logic [31:0] ram_word, status_word;

    dec_t        dec;
    logic        is_write, chan_push, stall, go;
    logic        sel_full, sel_empty, sel_pop;
    logic [CW-1:0] sel_cnt;

    logic [NUM_OUT-1:0]         push, pop, full, empty;
    logic [NUM_OUT-1:0][7:0]    dout;
    logic [NUM_OUT-1:0][CW-1:0] cnt;

    // The instruction-fetch flag is part of the bus but no behaviour depends on it.
    logic unused_instr;
    assign unused_instr = mem_instr;

    assign dec       = decode(addr_q, 32'(MEM_WORDS), OUT_BASE, NUM_OUT);
    assign widx      = addr_q[AW+1:2];
    assign ram_word  = ram[widx];
    assign is_write  = |wstrb_q;
    assign chan_push = (dec.kind == DEC_CHAN) && wstrb_q[0];
    // Hold the CPU only when the target FIFO is full and nothing drains this edge.
    assign stall     = chan_push && sel_full && !sel_pop;
    assign go        = (state_q == S_WAIT) && (wcnt_q == WS) && !stall;

    // Pick out the status of the channel the latched address targets.
    always_comb begin
        sel_full  = 1'b0;
        sel_empty = 1'b1;
        sel_pop   = 1'b0;
        sel_cnt   = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (dec.chan == 3'(k)) begin
                sel_full  = full[k];
                sel_empty = empty[k];
                sel_pop   = pop[k];
                sel_cnt   = cnt[k];
            end
        end
        status_word = '0;
        status_word[ST_EMPTY_BIT] = sel_empty;
        status_word[ST_FULL_BIT]  = sel_full;
        status_word[ST_CNT_LSB +: ST_CNT_W] = 8'(sel_cnt);
    end

    // Next-state and request datapath; the answer is registered on WAIT->RESP.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        bus_err_d = bus_err_q;
        // The cycle after RESP is blind so a lingering mem_valid is not re-accepted.
        skip_d    = (state_q == S_RESP);
        case (state_q)
            S_IDLE: begin
                if (mem_valid && !mem_ready && !skip_q) begin
                    state_d = S_WAIT;
                    wcnt_d  = '0;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                end
            end
            S_WAIT: begin
                if (wcnt_q != WS) begin
                    wcnt_d = wcnt_q + 3'd1;
                end else if (!stall) begin
                    state_d = S_RESP;
                    case (dec.kind)
                        DEC_RAM:  rdata_d = is_write ? 32'h0 : ram_word;
                        DEC_CHAN: rdata_d = is_write ? 32'h0 : status_word;
                        default: begin
                            rdata_d   = 32'h0;
                            bus_err_d = 1'b1;
                        end
                    endcase
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            skip_q    <= skip_d;
        end
    end

    // Byte-lane RAM write on the commit edge; an access cut by reset writes nothing.
    always_ff @(posedge clk) begin
        if (go && !reset && dec.kind == DEC_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) ram[widx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
        assign push[k] = go && chan_push && (dec.chan == 3'(k));
        byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[k]),
            .din   (wdata_q[7:0]),
            .pop   (pop[k]),
            .dout  (dout[k]),
            .full  (full[k]),
            .empty (empty[k]),
            .count (cnt[k])
        );
    end

    assign out_valid     = ~empty;
    assign pop           = out_valid & out_ready;
    assign out_data      = dout;
    assign mem_ready     = (state_q == S_RESP);
    assign mem_rdata     = rdata_q;
    assign bus_err       = bus_err_q;
    assign monitor_valid = mem_ready;
    assign monitor_addr  = addr_q;
    assign monitor_data  = is_write ? wdata_q : rdata_q;

endmodule

// File: tb/tb_soc_mem_ctrl.sv
// Randomised bench for soc_mem_ctrl against a transaction/queue reference model.
module tb_soc_mem_ctrl;

    localparam int          WS    = 2;
    localparam int          NOUT  = 2;
    localparam int          DEPTH = 4;
    localparam int          WORDS = 256;
    localparam logic [31:0] OBASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic mem_ready, bus_err, monitor_valid;
    logic [31:0] mem_rdata, monitor_addr, monitor_data;
    logic [NOUT-1:0] out_valid, out_ready = '0;
    logic [8*NOUT-1:0] out_data;

    always #5 clk = ~clk;

    soc_mem_ctrl #(
        .MEM_WORDS(WORDS), .WAIT_STATES(WS), .NUM_OUT(NOUT),
        .FIFO_DEPTH(DEPTH), .OUT_BASE(OBASE), .MEM_INIT("")
    ) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .bus_err(bus_err),
        .monitor_valid(monitor_valid), .monitor_addr(monitor_addr),
        .monitor_data(monitor_data)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: RAM words, per-channel byte queues, sticky error,
    // and the request timeline (accept, WS wait cycles, answer, two blind cycles).
    logic [31:0] m_ram [WORDS];
    logic [7:0]  mq [NOUT][$];
    bit          m_err = 0, m_done = 0;
    int          m_phase = 0, m_el = 0, m_gap = 2;
    logic [31:0] r_addr = '0, r_wdata = '0, e_rd = '0;
    logic [3:0]  r_wstrb = '0;
    bit          rdy_rand = 0;
    logic [NOUT-1:0] rdy_force = '0;

    function automatic void classify(input logic [31:0] a, output int kind, output int ch);
        kind = 2;
        ch = 0;
        if ((a >> 2) < 32'(WORDS)) kind = 0;
        else for (int k = 0; k < NOUT; k++)
            if (a == OBASE + 32'(4 * k)) begin kind = 1; ch = k; end
    endfunction

    task automatic tick();
        logic [NOUT-1:0] pops;
        int kind = 2, ch = 0, sz;
        bit rsp = 0;
        if (rdy_rand) out_ready = NOUT'($urandom_range(0, (1 << NOUT) - 1));
        else out_ready = rdy_force;
        mem_instr = 1'($urandom_range(0, 1));
        for (int k = 0; k < NOUT; k++) pops[k] = out_ready[k] && (mq[k].size() > 0);
        if (reset) begin
            for (int k = 0; k < NOUT; k++) mq[k].delete();
            m_phase = 0; m_gap = 2; m_err = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (mem_valid && m_gap >= 2) begin
                        r_addr = mem_addr; r_wdata = mem_wdata; r_wstrb = mem_wstrb;
                        m_phase = 1; m_el = 0;
                    end else if (m_gap < 2) m_gap++;
                end
                1: begin
                    classify(r_addr, kind, ch);
                    sz = mq[ch].size();
                    if (m_el >= WS && !(kind == 1 && r_wstrb[0] && sz == DEPTH && !pops[ch])) begin
                        rsp = 1; m_phase = 2; e_rd = 0;
                        if (kind == 0) begin
                            if (r_wstrb == 0) e_rd = m_ram[int'(r_addr >> 2)];
                            else for (int i = 0; i < 4; i++)
                                if (r_wstrb[i]) m_ram[int'(r_addr >> 2)][8*i +: 8] = r_wdata[8*i +: 8];
                        end else if (kind == 1) begin
                            if (r_wstrb == 0)
                                e_rd = {16'b0, 8'(sz), 6'b0, 1'(sz == DEPTH), 1'(sz == 0)};
                        end else m_err = 1;
                    end else m_el++;
                end
                default: begin m_phase = 0; m_gap = 1; end
            endcase
            for (int k = 0; k < NOUT; k++) if (pops[k]) void'(mq[k].pop_front());
            if (rsp && kind == 1 && r_wstrb[0]) mq[ch].push_back(r_wdata[7:0]);
        end
        @(posedge clk);
        #1;
        check("mem_ready", mem_ready, 32'(rsp));
        check("mon_valid", monitor_valid, 32'(rsp));
        check("bus_err", bus_err, 32'(m_err));
        for (int k = 0; k < NOUT; k++) begin
            check("out_valid", out_valid[k], 32'(mq[k].size() > 0));
            if (mq[k].size() > 0) check("out_data", out_data[8*k +: 8], mq[k][0]);
        end
        if (rsp) begin
            check("mon_addr", monitor_addr, r_addr);
            check("mon_data", monitor_data, (r_wstrb != 0) ? r_wdata : e_rd);
            if (r_wstrb == 0) check("rdata", mem_rdata, e_rd);
            mem_valid = 1'b0;
            m_done = 1;
        end
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int lat);
        mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_valid = 1'b1;
        m_done = 0; lat = 0;
        while (!m_done && lat < 80) begin tick(); lat++; end
        if (!m_done) begin check("timeout", 0, 1); mem_valid = 1'b0; end
        rd = mem_rdata;
    endtask

    task automatic drain();
        rdy_rand = 0; rdy_force = '1;
        idle(DEPTH + 2);
        rdy_force = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic [3:0]  ws;
        int lat, seen, kind;

        // Reset state
        reset = 1'b1;
        idle(2);
        check("rst_rdata", mem_rdata, 0);
        check("rst_mon_addr", monitor_addr, 0);
        check("rst_mon_data", monitor_data, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        reset = 1'b0;
        idle(2);

        // Known contents for the random RAM window (words 0..16)
        for (int w = 0; w <= 16; w++) begin
            access(32'(w * 4), (w == 16) ? 32'h0 : $urandom, 4'hF, rd, lat);
        end

        // Byte-lane write then read, with latency from acceptance
        idle(2);
        access(32'h40, 32'hDEAD_BEEF, 4'b0101, rd, lat);
        idle(2);
        access(32'h40, 32'h0, 4'b0000, rd, lat);
        check("ram_strb_rd", rd, 32'h00AD_00EF);
        check("ram_latency", 32'(lat - 1), 32'(WS + 1));

        // Channel 1 write, consumer ready
        drain();
        rdy_force = 2'b10;
        access(OBASE + 32'd4, 32'h0000_0041, 4'b0001, rd, lat);
        check("ch1_valid", 32'(out_valid[1]), 1);
        check("ch1_data", out_data[15:8], 32'h41);
        check("ch0_idle", 32'(out_valid[0]), 0);
        tick();
        check("ch1_popped", 32'(out_valid[1]), 0);
        idle(2);

        // Backpressure on channel 0
        drain();
        for (int i = 0; i < DEPTH; i++) access(OBASE, 32'(8'hA0 + i), 4'b0001, rd, lat);
        mem_addr = OBASE; mem_wdata = 32'hA4; mem_wstrb = 4'b0001; mem_valid = 1'b1; m_done = 0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin tick(); seen |= int'(mem_ready); end
        check("bp_stall", 32'(seen), 0);
        rdy_force = 2'b01;
        tick();
        rdy_force = 2'b00;
        check("bp_release", 32'(mem_ready), 1);
        idle(2);
        access(OBASE, 32'h0, 4'b0000, rd, lat);
        check("bp_status", rd, 32'h0000_0402);

        // Unmapped read, sticky error
        idle(2);
        access(32'h2000_0000, 32'h0, 4'b0000, rd, lat);
        check("unmapped_rd", rd, 0);
        check("bus_err_set", 32'(bus_err), 1);
        idle(5);
        check("bus_err_sticky", 32'(bus_err), 1);

        // Reset during WAIT: channel push and RAM write both aborted
        drain();
        access(32'h14, 32'h1111_1111, 4'hF, rd, lat);
        idle(2);
        mem_addr = OBASE; mem_wdata = 32'h77; mem_wstrb = 4'b0001; mem_valid = 1'b1;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0; mem_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); seen |= int'(mem_ready); end
        check("rst_abort_ready", 32'(seen), 0);
        check("rst_abort_push", 32'(out_valid), 0);
        check("rst_clears_err", 32'(bus_err), 0);
        mem_addr = 32'h14; mem_wdata = 32'h2222_2222; mem_wstrb = 4'hF; mem_valid = 1'b1;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0; mem_valid = 1'b0;
        idle(2);
        access(32'h14, 32'h0, 4'b0000, rd, lat);
        check("rst_abort_ram", rd, 32'h1111_1111);

        // Random mix with random consumer readiness
        rdy_rand = 1;
        for (int t = 0; t < 250; t++) begin
            kind = $urandom_range(0, 5);
            wd = $urandom;
            case (kind)
                0: begin a = 32'($urandom_range(0, 16) * 4); ws = 4'($urandom_range(1, 15)); end
                1: begin a = 32'($urandom_range(0, 16) * 4); ws = 4'h0; end
                2: begin a = OBASE + 32'($urandom_range(0, NOUT - 1) * 4);
                         ws = ($urandom_range(0, 3) == 0) ? 4'b0010 : 4'b0001; end
                3: begin a = OBASE + 32'($urandom_range(0, NOUT - 1) * 4); ws = 4'h0; end
                4: begin a = 32'h2000_0000 + 32'($urandom_range(0, 255) * 4); ws = 4'h0; end
                default: begin a = OBASE + 32'h100; ws = 4'hF; end
            endcase
            access(a, wd, ws, rd, lat);
            idle($urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
